// File: rtl/demux_8_1.sv
// demux_8_1: routes a 16-bit word stream into eight per-channel holding
// registers, each with its own valid/ack handshake toward a consumer.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_data/in_valid    offered word and its qualifier
//   in_ready            combinational: destination channel can take a word
//   Chooser             manual destination index (0 -> B1 .. 7 -> B8)
//   Auto                1 = destination from round-robin pointer, 0 = Chooser
//   B1..B8              per-channel holding registers
//   out_valid           bit k: channel k+1 holds an unconsumed word
//   out_ack             bit k: consumer k+1 takes its word this cycle
//   target              one-hot decode of the current destination
//   ptr                 round-robin pointer
module demux_8_1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  Chooser,
  input  logic        Auto,
  output logic [15:0] B1,
  output logic [15:0] B2,
  output logic [15:0] B3,
  output logic [15:0] B4,
  output logic [15:0] B5,
  output logic [15:0] B6,
  output logic [15:0] B7,
  output logic [15:0] B8,
  output logic [7:0]  out_valid,
  input  logic [7:0]  out_ack,
  output logic [7:0]  target,
  output logic [2:0]  ptr
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_CH   = 8;
  localparam int unsigned IDX_W  = 3;

  logic [DATA_W-1:0] b_q [N_CH];
  logic [DATA_W-1:0] b_d [N_CH];
  logic [N_CH-1:0]   valid_q;
  logic [N_CH-1:0]   valid_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_d;

  logic [IDX_W-1:0]  dst;
  logic              accept;

  // Destination select and handshake; in_ready depends only on state, mode
  // and the ack of the chosen channel, never on in_valid.
  always_comb begin
    dst         = Auto ? ptr_q : Chooser;
    target      = '0;
    target[dst] = 1'b1;
    in_ready    = ~valid_q[dst] | out_ack[dst];
    accept      = in_valid & in_ready;
  end

  // Next-state: acks drain any number of channels; an accept then (re)loads
  // its channel, so accept+ack on the same channel keeps valid set.
  always_comb begin
    b_d     = b_q;
    valid_d = valid_q & ~out_ack;
    ptr_d   = ptr_q;
    if (accept) begin
      b_d[dst]     = in_data;
      valid_d[dst] = 1'b1;
      // The pointer stalls on backpressure rather than hunting for a free slot.
      if (Auto) begin
        ptr_d = ptr_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset wins over any simultaneous accept or ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        b_q[k] <= '0;
      end
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign B1        = b_q[0];
  assign B2        = b_q[1];
  assign B3        = b_q[2];
  assign B4        = b_q[3];
  assign B5        = b_q[4];
  assign B6        = b_q[5];
  assign B7        = b_q[6];
  assign B8        = b_q[7];
  assign out_valid = valid_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux_8_1.sv
// Bench for demux_8_1: constant vector table, hand sequences for wrap and
// mid-operation reset, then random traffic against a behavioural model.
module tb_demux_8_1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  Chooser;
  logic        Auto;
  logic [15:0] B1, B2, B3, B4, B5, B6, B7, B8;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [7:0]  target;
  logic [2:0]  ptr;

  always #5 clk = ~clk;

  demux_8_1 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .Chooser(Chooser), .Auto(Auto),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
    .out_valid(out_valid), .out_ack(out_ack), .target(target), .ptr(ptr)
  );

  logic [15:0] b_dut [8];
  assign b_dut[0] = B1;
  assign b_dut[1] = B2;
  assign b_dut[2] = B3;
  assign b_dut[3] = B4;
  assign b_dut[4] = B5;
  assign b_dut[5] = B6;
  assign b_dut[6] = B7;
  assign b_dut[7] = B8;

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain arrays of channel contents and occupancy.
  int m_data [8];
  bit m_full [8];
  int m_ptr;
  int m_dst;
  bit m_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_data[k] = 0;
      m_full[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  // Before the edge: check destination decode and readiness.
  task automatic comb_phase();
    @(negedge clk);
    m_dst = (Auto == 1'b1) ? m_ptr : int'(Chooser);
    m_rdy = !m_full[m_dst] || (out_ack[m_dst] == 1'b1);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("target", 32'(target), 32'(1) << m_dst);
  endtask

  // After the edge: advance the model and compare all state.
  task automatic edge_phase();
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < 8; k++)
        if (out_ack[k] == 1'b1) m_full[k] = 1'b0;
      if (in_valid && m_rdy) begin
        m_data[m_dst] = int'(in_data);
        m_full[m_dst] = 1'b1;
        if (Auto == 1'b1) m_ptr = (m_ptr + 1) % 8;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(model_valid()));
    chk("ptr", 32'(ptr), 32'(m_ptr));
    for (int k = 0; k < 8; k++)
      chk($sformatf("B%0d", k + 1), 32'(b_dut[k]), 32'(m_data[k]));
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic [2:0] ch, input logic a, input logic [7:0] ack);
    reset = r; in_valid = v; in_data = d; Chooser = ch; Auto = a; out_ack = ack;
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic [2:0]  ch;
    logic        aut;
    logic [7:0]  ack;
    logic        exp_rdy;
    logic [7:0]  exp_tgt;
    logic [7:0]  exp_vld;
    logic [2:0]  exp_ptr;
    int          chk_ch;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //            rst  vld  data     ch   aut  ack    rdy  tgt    vld    ptr  chn  B
    vecs[0]  = '{1'b0,1'b1,16'hA5A5,3'd5,1'b0,8'h00,1'b1,8'h20,8'h20,3'd0,5,16'hA5A5};
    vecs[1]  = '{1'b0,1'b1,16'h1234,3'd5,1'b0,8'h00,1'b0,8'h20,8'h20,3'd0,5,16'hA5A5};
    vecs[2]  = '{1'b0,1'b1,16'h1234,3'd5,1'b0,8'h20,1'b1,8'h20,8'h20,3'd0,5,16'h1234};
    vecs[3]  = '{1'b0,1'b0,16'h0000,3'd5,1'b0,8'h20,1'b1,8'h20,8'h00,3'd0,5,16'h1234};
    vecs[4]  = '{1'b0,1'b0,16'h0000,3'd0,1'b0,8'h01,1'b1,8'h01,8'h00,3'd0,0,16'h0000};
    vecs[5]  = '{1'b0,1'b1,16'h1111,3'd7,1'b1,8'h00,1'b1,8'h01,8'h01,3'd1,0,16'h1111};
    vecs[6]  = '{1'b0,1'b1,16'h2222,3'd7,1'b1,8'h00,1'b1,8'h02,8'h03,3'd2,1,16'h2222};
    vecs[7]  = '{1'b0,1'b1,16'h3333,3'd7,1'b1,8'h00,1'b1,8'h04,8'h07,3'd3,2,16'h3333};
    vecs[8]  = '{1'b0,1'b1,16'h4444,3'd3,1'b0,8'h00,1'b1,8'h08,8'h0F,3'd3,3,16'h4444};
    vecs[9]  = '{1'b0,1'b1,16'h5555,3'd0,1'b1,8'h00,1'b0,8'h08,8'h0F,3'd3,3,16'h4444};
    vecs[10] = '{1'b0,1'b1,16'h5555,3'd0,1'b1,8'h08,1'b1,8'h08,8'h0F,3'd4,3,16'h5555};
    vecs[11] = '{1'b0,1'b0,16'h0000,3'd0,1'b1,8'h0F,1'b1,8'h10,8'h00,3'd4,3,16'h5555};
    vecs[12] = '{1'b1,1'b1,16'hFFFF,3'd0,1'b1,8'h00,1'b1,8'h10,8'h00,3'd0,3,16'h0000};
    vecs[13] = '{1'b0,1'b0,16'h0000,3'd0,1'b1,8'h00,1'b1,8'h01,8'h00,3'd0,0,16'h0000};

    drive(1'b1, 1'b0, 16'h0, 3'd0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", 32'(out_valid), 32'h00);
    chk("rst_ptr", 32'(ptr), 32'h0);
    chk("rst_B1", 32'(B1), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_target", 32'(target), 32'h01);
    chk("rst_ready", 32'(in_ready), 32'h1);

    // Constant vector table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].ch, vecs[i].aut, vecs[i].ack);
      comb_phase();
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_target", i), 32'(target), 32'(vecs[i].exp_tgt));
      edge_phase();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vecs[i].exp_ptr));
      chk($sformatf("vec%0d_B", i), 32'(b_dut[vecs[i].chk_ch]), 32'(vecs[i].exp_b));
    end

    // Round-robin wrap: nine accepts, channel 1 acked on the second one
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 16'(i + 1), 3'd0, 1'b1, (i == 1) ? 8'h01 : 8'h00);
      chk("wrap_ptr_seq", 32'(ptr), 32'(i % 8));
      comb_phase();
      chk("wrap_ready", 32'(in_ready), 32'h1);
      edge_phase();
    end
    for (int k = 0; k < 8; k++)
      chk("wrap_data", 32'(b_dut[k]), (k == 0) ? 32'd9 : 32'(k + 1));
    chk("wrap_ptr_end", 32'(ptr), 32'd1);
    chk("wrap_valid", 32'(out_valid), 32'hFF);

    // Accept+ack on the same full channel: no bubble, pointer walks to 6
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 16'hC000 + 16'(i), 3'd0, 1'b1, 8'(1) << (i + 1));
      comb_phase();
      edge_phase();
      chk("nobubble_valid", 32'(out_valid), 32'hFF);
    end
    chk("pre_rst_ptr", 32'(ptr), 32'd6);

    // Reset mid-operation with a word offered
    drive(1'b1, 1'b1, 16'hBEEF, 3'd2, 1'b1, 8'hFF);
    comb_phase();
    edge_phase();
    chk("midrst_valid", 32'(out_valid), 32'h00);
    chk("midrst_ptr", 32'(ptr), 32'h0);
    for (int k = 0; k < 8; k++)
      chk("midrst_B", 32'(b_dut[k]), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) != 0),
            16'($urandom()),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            8'($urandom() & $urandom()));
      comb_phase();
      edge_phase();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_8_1.md
DEMUX_8_1 -- requirements
Module: demux_8_1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and reset.
REQ-002 The block SHALL provide the following ports (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_data  input  16  word to distribute
- in_valid  input  1  in_data is offered this cycle
- in_ready  output  1  word accepted this cycle when high with in_valid
- Chooser  input  3  destination channel in manual mode; 0 selects channel 1 and 7 selects channel 8
- Auto  input  1  1 = round-robin destination from the internal pointer; 0 = destination from Chooser
- B1..B8  output  16 each  per-channel holding registers
- out_valid  output  8  bit k set = channel k+1 holds an unconsumed word
- out_ack  input  8  bit k set = consumer of channel k+1 takes its word this cycle
- target  output  8  one-hot destination for the current cycle
- ptr  output  3  round-robin pointer

Function
REQ-003 Destination index dst SHALL be Chooser when Auto=0 and ptr when Auto=1.
- target SHALL be the one-hot decode of dst (bit dst set).
REQ-004 in_ready SHALL be combinational: high when out_valid[dst]=0 or out_ack[dst]=1.
REQ-005 Accept occurs when in_valid=1 and in_ready=1 at a rising edge.
- On accept, in_data SHALL load into channel dst+1 and set out_valid[dst] on that edge.
- Latency SHALL be 1 cycle.
REQ-006 A channel SHALL hold its data and out_valid until acked; only an accept into that channel changes its data.
REQ-007 out_ack[k]=1 with out_valid[k]=1 and no accept into channel k SHALL clear out_valid[k] next edge; data is retained.
REQ-008 out_ack[k]=1 with out_valid[k]=0 SHALL be ignored.
REQ-009 Accept and ack on the same channel at the same edge SHALL load the new word and keep out_valid[k]=1 (no bubble).
REQ-010 Acks on other channels in the accept cycle SHALL be processed independently; any number of channels can drain per cycle.
REQ-011 When Auto=1, ptr SHALL increment by 1 on each accept, wrapping from 7 to 0.
- ptr SHALL not change when Auto=0 or when no accept occurs.
REQ-012 When Auto=1 and channel ptr+1 is full and not acked, in_ready SHALL be low; the pointer SHALL stall and not skip to a free channel.
REQ-013 Toggling Auto SHALL take effect the same cycle (dst recomputed combinationally); ptr SHALL retain its value across mode changes.
REQ-014 in_valid=1 with in_ready=0 SHALL change no state; the source holds in_data and Chooser until accepted.
REQ-015 The block SHALL not contain combinational paths from in_valid to in_ready.

Reset
REQ-016 With reset=1 at a rising edge, the following SHALL hold after that edge:
- B1..B8 = 16'h0000
- out_valid = 8'h00
- ptr = 0
REQ-017 Reset SHALL override any simultaneous accept or ack.
REQ-018 A word offered in the reset cycle SHALL be discarded.
REQ-019 After reset, target SHALL be 8'h01 when Auto=1, and in_ready SHALL be 1.

Verification
REQ-020 Manual routing: Auto=0, Chooser=5, in_data=16'hA5A5, in_valid=1 for one cycle.
- Next cycle: B6=16'hA5A5 and out_valid=8'h20.
- All other channels remain 0.
REQ-021 Backpressure: channel 6 full and unacked; offer Chooser=5, in_data=16'h1234.
- in_ready=0 and B6 unchanged.
- Then pulse out_ack[5]=1 with the word still offered: in_ready=1, B6=16'h1234 next cycle, out_valid[5] stays 1.
REQ-022 Round-robin wrap: Auto=1, 9 consecutive accepts of 16'h0001..16'h0009 with channel 1 acked after the first.
- B1..B8 receive 1..8, then B1=16'h0009.
- ptr sequence is 0,1,..,7,0,1.
REQ-023 Round-robin stall: Auto=1, ptr=3, channel 4 full, channel 5 empty.
- in_ready=0 and ptr stays 3.
- Ack channel 4: accept proceeds, ptr=4.
REQ-024 Reset mid-operation: out_valid=8'hFF, ptr=6, in_valid=1.
- Assert reset for one cycle.
- Next cycle: out_valid=8'h00, all B=16'h0000, ptr=0; the offered word is not stored.
